// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined two-level carry-lookahead adder/subtractor with a valid/ready handshake
module cla_pipe_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int NSTG = WIDTH / SEG;
   localparam int NG   = SEG / 4;

   // Returns {carry into segment MSB, segment carry-out, segment sum}
   function automatic logic [SEG+1:0] f_cla(input logic [SEG-1:0] x, input logic [SEG-1:0] y, input logic c);
      logic [SEG-1:0] p;
      logic [SEG-1:0] g;
      logic [SEG:0]   cb;
      logic [NG-1:0]  gp;
      logic [NG-1:0]  gg;
      logic [NG:0]    gc;
      p = x ^ y;
      g = x & y;
      for (int j = 0; j < NG; j++) begin
         gp[j] = &p[4*j +: 4];
         gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      end
      gc[0] = c;
      for (int j = 0; j < NG; j++)
         gc[j+1] = gg[j] | (gp[j] & gc[j]);
      cb = '0;
      for (int j = 0; j < NG; j++) begin
         cb[4*j] = gc[j];
         for (int i = 0; i < 3; i++)
            cb[4*j+i+1] = g[4*j+i] | (p[4*j+i] & cb[4*j+i]);
      end
      cb[SEG] = gc[NG];
      return {cb[SEG-1], cb[SEG], p ^ cb[SEG-1:0]};
   endfunction

   logic             r_v [NSTG];
   logic             r_c [NSTG];
   logic [WIDTH-1:0] r_a [NSTG];
   logic [WIDTH-1:0] r_b [NSTG];
   logic [WIDTH-1:0] r_s [NSTG];
   logic             r_o;

   logic             w_vi [NSTG];
   logic             w_ci [NSTG];
   logic [WIDTH-1:0] w_ai [NSTG];
   logic [WIDTH-1:0] w_bi [NSTG];
   logic [WIDTH-1:0] w_si [NSTG];
   logic [WIDTH-1:0] w_so [NSTG];
   logic [SEG+1:0]   w_r  [NSTG];
   logic             w_adv;

   assign w_adv     = !r_v[NSTG-1] | out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_v[NSTG-1];
   assign sum       = r_s[NSTG-1];
   assign cout      = r_c[NSTG-1];
   assign ovf       = r_o;

   // Stage inputs (operand prep at stage 0, previous registers otherwise) and per-stage segment add
   always_comb begin
      w_vi[0] = in_valid;
      w_ai[0] = a;
      w_bi[0] = sub ? ~b : b;
      w_ci[0] = sub | cin;
      w_si[0] = '0;
      for (int k = 1; k < NSTG; k++) begin
         w_vi[k] = r_v[k-1];
         w_ai[k] = r_a[k-1];
         w_bi[k] = r_b[k-1];
         w_ci[k] = r_c[k-1];
         w_si[k] = r_s[k-1];
      end
      for (int k = 0; k < NSTG; k++) begin
         w_r[k]               = f_cla(w_ai[k][k*SEG +: SEG], w_bi[k][k*SEG +: SEG], w_ci[k]);
         w_so[k]              = w_si[k];
         w_so[k][k*SEG +: SEG] = w_r[k][SEG-1:0];
      end
   end

   // Pipeline registers advance together under the global stall; reset discards every beat
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NSTG; k++) begin
            r_v[k] <= 1'b0;
            r_c[k] <= 1'b0;
            r_s[k] <= '0;
            r_a[k] <= '0;
            r_b[k] <= '0;
         end
         r_o <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < NSTG; k++) begin
            r_v[k] <= w_vi[k];
            r_c[k] <= w_r[k][SEG];
            r_s[k] <= w_so[k];
            r_a[k] <= w_ai[k];
            r_b[k] <= w_bi[k];
         end
         r_o <= w_r[NSTG-1][SEG+1] ^ w_r[NSTG-1][SEG];
      end
   end
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: scoreboard bench for the pipelined CLA adder/subtractor
module tb_cla_pipe_adder;
   localparam int W    = 32;
   localparam int S    = 16;
   localparam int NSTG = W / S;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
   } exp_t;

   logic         clk = 0;
   logic         rst = 1;
   logic         in_valid = 0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 0;
   logic         sub = 0;
   logic         out_valid;
   logic         out_ready = 1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int   n_chk = 0;
   int   n_fail = 0;
   bit   rnd_rdy = 0;
   exp_t q[$];
   logic         p_hold = 0;
   logic [W-1:0] p_sum = '0;
   logic         p_c = 0;
   logic         p_o = 0;

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(W), .SEG(S)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   task automatic chk(input string nm, input logic [W+1:0] got, input logic [W+1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
      logic [W-1:0] be;
      logic [W:0]   r;
      exp_t         e;
      be  = ts ? ~tb : tb;
      r   = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, ts | tc};
      e.s = r[W-1:0];
      e.c = r[W];
      e.o = (ta[W-1] == be[W-1]) && (r[W-1] != ta[W-1]);
      return e;
   endfunction

   // Called #1 after a rising edge; returns #1 after the edge that accepted the beat
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts,
                       input logic [W-1:0] es, input logic ec, input logic eo);
      int t = 0;
      exp_t e;
      e.s = es; e.c = ec; e.o = eo;
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1;
      @(negedge clk);
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
      end else
         q.push_back(e);
      @(posedge clk);
      #1 in_valid = 0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      chk("drain_empty", q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on each transfer and checks that a stalled result stays put
   always @(negedge clk) begin
      exp_t e;
      if (rst)
         p_hold = 0;
      else begin
         if (p_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", {sum, cout, ovf}, {p_sum, p_c, p_o});
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL spurious_result: got sum=%h with nothing expected", sum);
            end else begin
               e = q.pop_front();
               chk("result", {sum, cout, ovf}, {e.s, e.c, e.o});
            end
         end
         p_hold = out_valid && !out_ready;
         p_sum  = sum;
         p_c    = cout;
         p_o    = ovf;
      end
   end

   always begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      int t;
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rc;
      logic        rs;
      exp_t        e;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("reset_state", {sum, cout, ovf}, '0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      send(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0);
      for (int i = 1; i < NSTG; i++) begin
         @(negedge clk);
         chk("latency_early", out_valid, 0);
      end
      @(negedge clk);
      chk("latency_due", out_valid, 1);
      @(posedge clk);
      #1;
      send(32'h5, 32'h7, 0, 1, 32'hFFFF_FFFE, 0, 0);
      send(32'h7, 32'h5, 0, 1, 32'h2, 1, 0);
      send(32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1);
      send(32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0, 1, 1);
      send(32'h1, 32'h2, 1, 0, 32'h4, 0, 0);
      send(32'hA, 32'h3, 1, 1, 32'h7, 1, 0);
      send(32'h0, 32'h0, 0, 1, 32'h0, 1, 0);
      send(32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1);
      send(32'h0000_FFFF, 32'h1, 0, 0, 32'h0001_0000, 0, 0);
      drain();
      out_ready = 0;
      fork
         begin
            send(32'h10, 32'h20, 0, 0, 32'h30, 0, 0);
            send(32'hFFFF, 32'h1, 0, 0, 32'h1_0000, 0, 0);
            send(32'h1234_5678, 32'h1111_1111, 0, 0, 32'h2345_6789, 0, 0);
         end
         begin
            t = 0;
            @(negedge clk);
            while (!out_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            for (int i = 0; i < 3; i++) begin
               if (i != 0) @(negedge clk);
               chk("stall_out_valid", out_valid, 1);
               chk("stall_in_ready", in_ready, 0);
            end
            @(posedge clk);
            #1 out_ready = 1;
         end
      join
      drain();
      out_ready = 0;
      send(32'h1, 32'h2, 0, 0, 32'h3, 0, 0);
      send(32'h3, 32'h4, 0, 0, 32'h7, 0, 0);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      q.delete();
      @(negedge clk);
      chk("rst_flush", out_valid, 0);
      out_ready = 1;
      repeat (6) begin
         @(negedge clk);
         chk("no_stale", out_valid, 0);
      end
      @(posedge clk);
      #1 rnd_rdy = 1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         ra = {$urandom(), $urandom()};
         rb = {$urandom(), $urandom()};
         if ($urandom_range(0, 7) == 0) ra = '1;
         if ($urandom_range(0, 7) == 0) rb = {32'h0, 32'h8000_0000};
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         e = model(ra[W-1:0], rb[W-1:0], rc, rs);
         send(ra[W-1:0], rb[W-1:0], rc, rs, e.s, e.c, e.o);
      end
      rnd_rdy = 0;
      out_ready = 1;
      drain();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
